tdc_hit_reader: RTL and testbench
=================================

Name: tdc_hit_reader

Overview:
- Consumer side of the carry-chain TDC. The delay-line block latches a 32-bit thermometer snapshot (`tdc_word`) on the asynchronous `stop` edge; this block reads it out in the system clock domain.
- Per hit it:
  - synchronises the stop event into `clk`;
  - samples the held snapshot;
  - decodes it to a fine count, with a bubble check;
  - tags it with a free-running coarse counter;
  - buffers the timestamp in a FIFO drained by a valid/ready consumer (AXI-stream wrapper or CPU readout).

Parameters:
- COARSE_W, 24, width of the free-running coarse counter and of `out_coarse`.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  capture enable, synchronous to clk.
- stop_in  in  1  raw stop pulse, asynchronous to clk; the same net that latches `tdc_word`.
- tdc_word  in  32  thermometer snapshot; stable from the stop rising edge until the next stop rising edge.
- out_valid  out  1  FIFO head holds a valid event.
- out_ready  in  1  consumer accepts the head when out_valid&out_ready at a clk edge.
- out_coarse  out  COARSE_W  coarse count at capture.
- out_fine  out  6  popcount of the snapshot, range 0..32.
- out_bubble  out  1  snapshot was not a clean thermometer code.
- fifo_level  out  FIFO_AW+1  number of entries held, range 0..2**FIFO_AW.
- overflow_cnt  out  8  events dropped because the FIFO was full; saturates at 255.
- clear_ovf  in  1  synchronous clear of overflow_cnt.

Behaviour:

Reset (rst_n low, asynchronous):
- Clears sync flops, coarse counter, pipeline registers, FIFO pointers and overflow_cnt.
- Outputs while in reset: out_valid=0, out_coarse=0, out_fine=0, out_bubble=0, fifo_level=0, overflow_cnt=0.
- Reset asserted mid-operation discards all buffered and in-flight events.

Synchroniser and capture:
- stop_in goes through a 2-flop synchroniser (s0, s1), then a delay flop sd.
- Capture condition at a clk edge: `s1 & ~sd & en`.
- Event timing, where edge 1 is the first edge at which s0 samples stop_in high:
  - edge 3 is the capture edge;
  - at edge 3, register `tdc_word` into W and the current coarse count into C.
- sd keeps tracking s1 while en=0, so raising en during a high stop_in causes no capture.
- Stop pulses must be high at least 2 clk periods and low at least 2 clk periods. Closer pulses merge into one event; this is not flagged.

Coarse counter:
- Increments every clk from reset.
- Wraps modulo 2**COARSE_W, with no flag.

Decode (registered at edge 4):
- fine = number of 1 bits in W, 6 bits.
- bubble = 1 iff W != (2**fine - 1), i.e. the ones are not contiguous from bit 0.
- W=0 gives fine=0 and bubble=0. W=all-ones gives fine=32 and bubble=0.

FIFO write (edge 5):
- Entry {C, fine, bubble} is pushed; out_valid is high after edge 5 when the FIFO was empty.
- Latency from edge 1 to out_valid is 5 clk edges.

FIFO read:
- Show-ahead: out_* always reflect the head entry.
- Pop on out_valid & out_ready.
- out_* are don't-care when out_valid=0; the bench must not check them.

Full-FIFO rules:
- Push with no pop while full: the entry is dropped and overflow_cnt increments by 1, saturating at 255.
- Push and pop in the same cycle while full: the push is accepted and fifo_level stays 2**FIFO_AW.
- Push and pop in the same cycle while empty: no bypass. The new entry becomes visible the next cycle and is not popped.

fifo_level:
- Registered.
- Updates at the same edge as the push or pop.

clear_ovf:
- Sets overflow_cnt to 0 at the next edge.
- If a drop occurs in the same cycle, the result is 0; clear wins.

Test Plan:
1. Single hit, tdc_word=32'h0000_07FF, stop high 4 cycles, coarse=100 at the capture edge -> out_valid high after edge 5; out_fine=11, out_bubble=0, out_coarse=100; pop with out_ready -> out_valid=0, fifo_level=0.
2. Bubble and extremes. Three hits spaced 8 cycles apart with tdc_word = 32'h0000_0F7F, then 32'h0000_0000, then 32'hFFFF_FFFF. Expected pops in order:
   - hit 1: fine=11, bubble=1;
   - hit 2: fine=0, bubble=0;
   - hit 3: fine=32, bubble=0;
   - coarse values are strictly increasing, 8 apart.
3. Overflow with FIFO_AW=4 and out_ready=0: 20 hits -> fifo_level=16 and overflow_cnt=4. Pulse clear_ovf -> overflow_cnt=0. Drain all 16 -> FIFO order preserved.
4. Full with simultaneous pop: FIFO full, hit arrives with out_ready=1 on the push cycle -> fifo_level stays 16 and overflow_cnt is unchanged.
5. Enable gating: en=0 during a hit -> no entry is written. Raise en while stop_in is still high -> no capture. Next clean hit with en=1 is captured.
6. Reset mid-operation: 5 buffered entries plus one hit in the pipeline, pulse rst_n low asynchronously between edges -> all outputs are 0 immediately, and after release no stale entry appears (out_valid stays 0).

Source files
------------

// File: rtl/tdc_hit_reader.sv
// Clock-domain readout for the carry-chain TDC. Captures the held thermometer
// snapshot on each synchronised stop edge, decodes it and buffers timestamps.
module tdc_hit_reader #(
  parameter int COARSE_W = 24,
  parameter int FIFO_AW  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                stop_in,
  input  logic [31:0]         tdc_word,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [COARSE_W-1:0] out_coarse,
  output logic [5:0]          out_fine,
  output logic                out_bubble,
  output logic [FIFO_AW:0]    fifo_level,
  output logic [7:0]          overflow_cnt,
  input  logic                clear_ovf
);

  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int ENTRY_W = COARSE_W + 7;
  localparam logic [FIFO_AW:0] FULL_LEVEL = {1'b1, {FIFO_AW{1'b0}}};

  logic s0, s1, sd;
  logic capture;

  logic [COARSE_W-1:0] coarse;

  logic                cap_valid;
  logic [31:0]         cap_word;
  logic [COARSE_W-1:0] cap_coarse;

  logic [5:0]          fine_next;
  logic [32:0]         thermo_mask;
  logic                bubble_next;

  logic                dec_valid;
  logic [COARSE_W-1:0] dec_coarse;
  logic [5:0]          dec_fine;
  logic                dec_bubble;

  logic [ENTRY_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
  logic [FIFO_AW:0]    count;
  logic [ENTRY_W-1:0]  head;
  logic                full, pop, push_ok, drop;

  function automatic logic [5:0] popcount32(input logic [31:0] w);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + 6'(w[i]);
    return n;
  endfunction

  // sd keeps following s1 regardless of en, so a late enable never fakes an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      sd <= 1'b0;
    end else begin
      s0 <= stop_in;
      s1 <= s0;
      sd <= s1;
    end
  end

  assign capture = s1 & ~sd & en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coarse <= '0;
    else        coarse <= coarse + COARSE_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid  <= 1'b0;
      cap_word   <= '0;
      cap_coarse <= '0;
    end else begin
      cap_valid <= capture;
      if (capture) begin
        cap_word   <= tdc_word;
        cap_coarse <= coarse;
      end
    end
  end

  // A clean code is exactly the low 'fine' bits set; anything else is a bubble
  always_comb begin
    fine_next   = popcount32(cap_word);
    thermo_mask = (33'd1 << fine_next) - 33'd1;
    bubble_next = ({1'b0, cap_word} != thermo_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_valid  <= 1'b0;
      dec_coarse <= '0;
      dec_fine   <= '0;
      dec_bubble <= 1'b0;
    end else begin
      dec_valid <= cap_valid;
      if (cap_valid) begin
        dec_coarse <= cap_coarse;
        dec_fine   <= fine_next;
        dec_bubble <= bubble_next;
      end
    end
  end

  assign out_valid = (count != '0);
  assign full      = (count == FULL_LEVEL);
  assign pop       = out_valid & out_ready;
  assign push_ok   = dec_valid & (~full | pop);
  assign drop      = dec_valid & full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {dec_coarse, dec_fine, dec_bubble};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
      if (push_ok && !pop)      count <= count + (FIFO_AW+1)'(1);
      else if (pop && !push_ok) count <= count - (FIFO_AW+1)'(1);
    end
  end

  // Clear beats a simultaneous drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              overflow_cnt <= '0;
    else if (clear_ovf)                      overflow_cnt <= '0;
    else if (drop && overflow_cnt != 8'hFF)  overflow_cnt <= overflow_cnt + 8'd1;
  end

  // Head fields are forced to zero when empty so reset shows clean outputs
  assign head       = mem[rd_ptr];
  assign out_coarse = out_valid ? head[ENTRY_W-1 -: COARSE_W] : '0;
  assign out_fine   = out_valid ? head[6:1] : '0;
  assign out_bubble = out_valid ? head[0] : 1'b0;
  assign fifo_level = count;

endmodule

// File: tb/tb_tdc_hit_reader.sv
// Self-checking bench for tdc_hit_reader: directed scenarios plus random hits,
// compared every cycle against a queue-based event model.
module tb_tdc_hit_reader;
  localparam int CW    = 24;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic          stop_in = 1'b0;
  logic [31:0]   tdc_word = '0;
  logic          out_ready = 1'b0;
  logic          clear_ovf = 1'b0;
  logic          out_valid;
  logic [CW-1:0] out_coarse;
  logic [5:0]    out_fine;
  logic          out_bubble;
  logic [AW:0]   fifo_level;
  logic [7:0]    overflow_cnt;

  tdc_hit_reader #(.COARSE_W(CW), .FIFO_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .stop_in(stop_in), .tdc_word(tdc_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_coarse(out_coarse),
    .out_fine(out_fine), .out_bubble(out_bubble), .fifo_level(fifo_level),
    .overflow_cnt(overflow_cnt), .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] coarse;
    logic [5:0]    fine;
    logic          bubble;
  } ev_t;

  ev_t           mq[$];
  ev_t           pq[$];
  int            pdue[$];
  bit            h0, h1, h2;
  int            ecount = 0;
  logic [CW-1:0] mcoarse = '0;
  int            movf = 0;
  int            n_cmp = 0;
  int            n_fail = 0;
  bit            rand_mode = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Event-level model: capture two edges after stop is first seen high, push two later
  always @(posedge clk or negedge rst_n) begin : model_step
    bit   pop, full, drop, samp;
    ev_t  e;
    int   f;
    if (!rst_n) begin
      mq.delete(); pq.delete(); pdue.delete();
      h0 = 0; h1 = 0; h2 = 0;
      ecount = 0; mcoarse = '0; movf = 0;
    end else begin
      ecount++;
      samp = stop_in;
      full = (mq.size() == DEPTH);
      pop  = (mq.size() != 0) && out_ready;
      drop = 0;
      if (h1 && !h2 && en) begin
        f        = $countones(tdc_word);
        e.coarse = mcoarse;
        e.fine   = 6'(f);
        e.bubble = ({1'b0, tdc_word} != ((33'd1 << f) - 33'd1));
        pq.push_back(e);
        pdue.push_back(ecount + 2);
      end
      if (pop) void'(mq.pop_front());
      if (pdue.size() != 0 && pdue[0] == ecount) begin
        e = pq.pop_front();
        void'(pdue.pop_front());
        if (!full || pop) mq.push_back(e);
        else              drop = 1;
      end
      if (clear_ovf)              movf = 0;
      else if (drop && movf < 255) movf++;
      h2 = h1; h1 = h0; h0 = samp;
      mcoarse = mcoarse + CW'(1);
    end
  end

  always @(negedge clk) begin
    check_output("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check_output("fifo_level", 32'(fifo_level), 32'(mq.size()));
    check_output("overflow_cnt", 32'(overflow_cnt), 32'(movf));
    if (mq.size() != 0) begin
      check_output("out_coarse", 32'(out_coarse), 32'(mq[0].coarse));
      check_output("out_fine", 32'(out_fine), 32'(mq[0].fine));
      check_output("out_bubble", 32'(out_bubble), 32'(mq[0].bubble));
    end
  end

  function automatic logic [31:0] thermo(input int n);
    logic [32:0] m;
    m = (33'd1 << n) - 33'd1;
    return m[31:0];
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [31:0] w, input int hi, input int lo);
    stop_in  = 1'b1;
    tdc_word = w;
    repeat (hi) begin
      @(negedge clk);
      if (rand_mode) begin
        out_ready = ($urandom_range(0, 3) == 0);
        clear_ovf = ($urandom_range(0, 19) == 0);
      end
    end
    stop_in = 1'b0;
    repeat (lo) begin
      @(negedge clk);
      if (rand_mode) begin
        out_ready = ($urandom_range(0, 3) == 0);
        clear_ovf = ($urandom_range(0, 19) == 0);
      end
    end
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = thermo($urandom_range(0, 32));
    if ($urandom_range(0, 2) == 0) w = w ^ (32'd1 << $urandom_range(0, 31));
    return w;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    wait_cycles(3);
    check_output("reset_valid", 32'(out_valid), 32'd0);
    check_output("reset_level", 32'(fifo_level), 32'd0);
    rst_n = 1'b1;

    // single clean hit whose capture edge sees coarse = 100
    while (ecount < 98) @(negedge clk);
    apply_stimulus(32'h0000_07FF, 4, 0);
    check_output("t1_latency_not_yet", 32'(out_valid), 32'd0);
    wait_cycles(1);
    check_output("t1_valid", 32'(out_valid), 32'd1);
    check_output("t1_coarse", 32'(out_coarse), 32'd100);
    check_output("t1_fine", 32'(out_fine), 32'd11);
    check_output("t1_bubble", 32'(out_bubble), 32'd0);
    pop_one();
    check_output("t1_popped_valid", 32'(out_valid), 32'd0);
    check_output("t1_popped_level", 32'(fifo_level), 32'd0);
    wait_cycles(4);

    // bubble, empty and full-scale codes spaced 8 cycles
    apply_stimulus(32'h0000_0F7F, 4, 4);
    apply_stimulus(32'h0000_0000, 4, 4);
    apply_stimulus(32'hFFFF_FFFF, 4, 4);
    wait_cycles(6);
    check_output("t2_model_depth", 32'(mq.size()), 32'd3);
    if (mq.size() == 3) begin
      check_output("t2_model_fine0", 32'(mq[0].fine), 32'd11);
      check_output("t2_model_gap1", 32'(mq[1].coarse - mq[0].coarse), 32'd8);
      check_output("t2_model_gap2", 32'(mq[2].coarse - mq[1].coarse), 32'd8);
    end
    check_output("t2_fine1", 32'(out_fine), 32'd11);
    check_output("t2_bubble1", 32'(out_bubble), 32'd1);
    pop_one();
    check_output("t2_fine2", 32'(out_fine), 32'd0);
    check_output("t2_bubble2", 32'(out_bubble), 32'd0);
    pop_one();
    check_output("t2_fine3", 32'(out_fine), 32'd32);
    check_output("t2_bubble3", 32'(out_bubble), 32'd0);
    pop_one();
    check_output("t2_empty", 32'(out_valid), 32'd0);

    // overflow with consumer stalled
    for (int i = 0; i < 20; i++) apply_stimulus(rand_word(), 2, 2);
    wait_cycles(4);
    check_output("t3_level_full", 32'(fifo_level), 32'd16);
    check_output("t3_ovf", 32'(overflow_cnt), 32'd4);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    check_output("t3_ovf_cleared", 32'(overflow_cnt), 32'd0);
    out_ready = 1'b1;
    wait_cycles(16);
    out_ready = 1'b0;
    check_output("t3_drained", 32'(fifo_level), 32'd0);

    // push into a full FIFO while the head is popped
    for (int i = 0; i < 16; i++) apply_stimulus(rand_word(), 2, 2);
    wait_cycles(4);
    check_output("t4_level_full", 32'(fifo_level), 32'd16);
    stop_in  = 1'b1;
    tdc_word = rand_word();
    repeat (2) @(negedge clk);
    stop_in = 1'b0;
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_output("t4_level_stays", 32'(fifo_level), 32'd16);
    check_output("t4_ovf_unchanged", 32'(overflow_cnt), 32'd0);
    out_ready = 1'b1;
    wait_cycles(18);
    out_ready = 1'b0;

    // enable gating
    en = 1'b0;
    apply_stimulus(rand_word(), 3, 3);
    wait_cycles(4);
    check_output("t5_gated", 32'(fifo_level), 32'd0);
    stop_in  = 1'b1;
    tdc_word = rand_word();
    wait_cycles(4);
    en = 1'b1;
    wait_cycles(3);
    stop_in = 1'b0;
    wait_cycles(6);
    check_output("t5_late_enable", 32'(fifo_level), 32'd0);
    apply_stimulus(rand_word(), 2, 2);
    wait_cycles(4);
    check_output("t5_clean_hit", 32'(fifo_level), 32'd1);
    pop_one();

    // randomized hits, stalls, enables and clears
    rand_mode = 1;
    for (int i = 0; i < 80; i++) begin
      en = ($urandom_range(0, 7) != 0);
      apply_stimulus(rand_word(), $urandom_range(2, 5), $urandom_range(2, 5));
    end
    rand_mode = 0;
    en        = 1'b1;
    clear_ovf = 1'b1;
    out_ready = 1'b1;
    wait_cycles(22);
    clear_ovf = 1'b0;
    out_ready = 1'b0;
    check_output("rand_drained", 32'(fifo_level), 32'd0);

    // asynchronous reset with buffered and in-flight events
    for (int i = 0; i < 5; i++) apply_stimulus(rand_word(), 2, 2);
    wait_cycles(4);
    check_output("t6_level5", 32'(fifo_level), 32'd5);
    stop_in  = 1'b1;
    tdc_word = rand_word();
    repeat (2) @(negedge clk);
    stop_in = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("t6_rst_valid", 32'(out_valid), 32'd0);
    check_output("t6_rst_coarse", 32'(out_coarse), 32'd0);
    check_output("t6_rst_fine", 32'(out_fine), 32'd0);
    check_output("t6_rst_bubble", 32'(out_bubble), 32'd0);
    check_output("t6_rst_level", 32'(fifo_level), 32'd0);
    check_output("t6_rst_ovf", 32'(overflow_cnt), 32'd0);
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(12);
    check_output("t6_no_stale", 32'(out_valid), 32'd0);
    check_output("t6_level_after", 32'(fifo_level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
